// File: rtl/sgd_rd_x_from_memory_pkg.sv
// sgd_rd_x_from_memory_pkg: shared sgd defaults and helpers for the x loader
package sgd_rd_x_from_memory_pkg;
    localparam int ENGINE_NUM_DEF        = 8;
    localparam int NUM_BITS_PER_BANK_DEF = 64;
    localparam int DIS_X_BIT_DEPTH_DEF   = 9;
    localparam int BEAT_W                = 512;
    localparam int BEAT_BYTES            = 64;
    // ceil(dim/per_row) without the dim+per_row-1 overflow near 2^32
    function automatic logic [31:0] x_rows(input logic [31:0] dim, input logic [31:0] per_row);
        return dim / per_row + 32'(dim % per_row != 0);
    endfunction
endpackage

// File: rtl/sgd_rd_x_from_memory.sv
// sgd_rd_x_from_memory: issue one host read for vector x and pack 512-bit beats into per-engine bank rows
// Ports: clk/rst (sync, active high); start/addr_model/dimension kick off a load, load_done pulses at the end;
// x_data_rd_* is the read command, x_data_in* the beat stream; x_mem_wr_* writes one bank word to the
// engine selected by the one-hot enable; state_counters_rd_x_from_memory = {state, accepted beats}.
module sgd_rd_x_from_memory
    import sgd_rd_x_from_memory_pkg::*;
#(
    parameter int ENGINE_NUM        = ENGINE_NUM_DEF,
    parameter int NUM_BITS_PER_BANK = NUM_BITS_PER_BANK_DEF,
    parameter int DIS_X_BIT_DEPTH   = DIS_X_BIT_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [63:0]                    addr_model,
    input  logic [31:0]                    dimension,
    output logic                           load_done,
    output logic [31:0]                    state_counters_rd_x_from_memory,
    output logic                           x_data_rd_start,
    output logic [63:0]                    x_data_rd_addr,
    output logic [31:0]                    x_data_rd_length,
    input  logic [511:0]                   x_data_in,
    input  logic                           x_data_in_valid,
    output logic                           x_data_in_ready,
    output logic [DIS_X_BIT_DEPTH-1:0]     x_mem_wr_addr,
    output logic [NUM_BITS_PER_BANK*32-1:0] x_mem_wr_data,
    output logic [ENGINE_NUM-1:0]          x_mem_wr_en
);
    localparam int BANK_W = NUM_BITS_PER_BANK * 32;
    localparam int GROUP  = BANK_W / BEAT_W;
    localparam int GW     = GROUP > 1 ? $clog2(GROUP) : 1;
    localparam int EW     = ENGINE_NUM > 1 ? $clog2(ENGINE_NUM) : 1;
    localparam logic [31:0] PER_ROW       = 32'(ENGINE_NUM * NUM_BITS_PER_BANK);
    localparam logic [31:0] BEATS_PER_ROW = 32'(ENGINE_NUM * GROUP);
    localparam logic [ENGINE_NUM-1:0] EN_ONE = 1;

    typedef enum logic [3:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                     state;
    logic [31:0]                total_beats;
    logic [31:0]                beats;
    logic [27:0]                beat_cnt;
    logic [GW-1:0]              inner;
    logic [EW-1:0]              engine;
    logic [DIS_X_BIT_DEPTH-1:0] row;
    logic [31:0]                beats_calc;
    logic                       accept;

    assign beats_calc      = x_rows(dimension, PER_ROW) * BEATS_PER_ROW;
    assign accept          = x_data_in_valid && x_data_in_ready;
    assign x_data_rd_start = state == CMD;
    assign x_data_in_ready = state == DATA;
    assign load_done       = state == DONE;
    assign state_counters_rd_x_from_memory = {state, beat_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            total_beats      <= '0;
            beats            <= '0;
            beat_cnt         <= '0;
            inner            <= '0;
            engine           <= '0;
            row              <= '0;
            x_data_rd_addr   <= '0;
            x_data_rd_length <= '0;
            x_mem_wr_addr    <= '0;
            x_mem_wr_data    <= '0;
            x_mem_wr_en      <= '0;
        end else begin
            x_mem_wr_en <= '0;
            case (state)
                IDLE: if (start) begin
                    x_data_rd_addr   <= addr_model;
                    x_data_rd_length <= beats_calc * 32'(BEAT_BYTES);
                    total_beats      <= beats_calc;
                    beats            <= '0;
                    beat_cnt         <= '0;
                    inner            <= '0;
                    engine           <= '0;
                    row              <= '0;
                    state            <= dimension == '0 ? DONE : CMD;
                end
                CMD: state <= DATA;
                DATA: if (accept) begin
                    x_mem_wr_data[BEAT_W*inner +: BEAT_W] <= x_data_in;
                    beats    <= beats + 1;
                    beat_cnt <= &beat_cnt ? beat_cnt : beat_cnt + 1;
                    inner    <= inner == GW'(GROUP - 1) ? '0 : inner + 1;
                    // the group is complete once the last slice lands; write it next cycle
                    if (inner == GW'(GROUP - 1)) begin
                        x_mem_wr_en   <= EN_ONE << engine;
                        x_mem_wr_addr <= row;
                        engine        <= engine == EW'(ENGINE_NUM - 1) ? '0 : engine + 1;
                        if (engine == EW'(ENGINE_NUM - 1))
                            row <= row + 1;
                    end
                    if (beats + 1 == total_beats)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// tb_sgd_rd_x_from_memory: randomized self-checking bench against a queue-based load model
module tb_sgd_rd_x_from_memory;
    localparam int EN = 8;
    localparam int PER_ROW = 512;
    localparam int GROUP = 4;

    logic           clk = 0;
    logic           rst = 1;
    logic           start = 0;
    logic [63:0]    addr_model = '0;
    logic [31:0]    dimension = '0;
    logic           load_done;
    logic [31:0]    state_counters;
    logic           x_data_rd_start;
    logic [63:0]    x_data_rd_addr;
    logic [31:0]    x_data_rd_length;
    logic [511:0]   x_data_in = '0;
    logic           x_data_in_valid = 0;
    logic           x_data_in_ready;
    logic [8:0]     x_mem_wr_addr;
    logic [2047:0]  x_mem_wr_data;
    logic [7:0]     x_mem_wr_en;

    int checks = 0, errors = 0, cyc = 0;
    int n_rd_start, n_done, done_with_wr, done_cyc;
    logic [63:0] rd_addr_q[$];
    logic [31:0] rd_len_q[$];
    int          wr_row_q[$];
    logic [7:0]  wr_en_q[$];
    logic [63:0] wr_fp_q[$];
    logic [511:0] bq[$];

    sgd_rd_x_from_memory dut (
        .clk(clk), .rst(rst), .start(start), .addr_model(addr_model), .dimension(dimension),
        .load_done(load_done), .state_counters_rd_x_from_memory(state_counters),
        .x_data_rd_start(x_data_rd_start), .x_data_rd_addr(x_data_rd_addr),
        .x_data_rd_length(x_data_rd_length), .x_data_in(x_data_in),
        .x_data_in_valid(x_data_in_valid), .x_data_in_ready(x_data_in_ready),
        .x_mem_wr_addr(x_mem_wr_addr), .x_mem_wr_data(x_mem_wr_data), .x_mem_wr_en(x_mem_wr_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // position-sensitive fingerprint so misplaced slices are caught
    function automatic logic [63:0] fold(input logic [2047:0] d);
        logic [63:0] r = '0;
        for (int i = 0; i < 32; i++) begin
            logic [63:0] c = d[64*i +: 64];
            r ^= (c << i) | (c >> (64 - i));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (x_data_rd_start) begin
                n_rd_start++;
                rd_addr_q.push_back(x_data_rd_addr);
                rd_len_q.push_back(x_data_rd_length);
            end
            if (|x_mem_wr_en) begin
                check("wr_onehot", 64'($onehot(x_mem_wr_en)), 64'd1);
                wr_row_q.push_back(int'(x_mem_wr_addr));
                wr_en_q.push_back(x_mem_wr_en);
                wr_fp_q.push_back(fold(x_mem_wr_data));
            end
            if (load_done) begin
                n_done++;
                done_cyc = cyc;
                if (|x_mem_wr_en) done_with_wr++;
            end
        end
    end

    task automatic clear_mon();
        n_rd_start = 0; n_done = 0; done_with_wr = 0; done_cyc = 0;
        rd_addr_q.delete(); rd_len_q.delete(); wr_row_q.delete(); wr_en_q.delete(); wr_fp_q.delete();
    endtask

    task automatic run_load(input int dim, input logic [63:0] addr, input int pct,
                            input int restart_at, input int abort_at);
        int rows, nbeats, idx, guard, s, rs;
        logic acc;
        logic [511:0] b;
        rows = dim / PER_ROW + ((dim % PER_ROW) != 0 ? 1 : 0);
        nbeats = rows * EN * GROUP;
        bq.delete();
        for (int k = 0; k < nbeats; k++) begin
            for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
            bq.push_back(b);
        end
        clear_mon();
        s = cyc;
        start = 1; dimension = dim; addr_model = addr;
        @(posedge clk); #1;
        start = 0;
        idx = 0; guard = 0; rs = 0;
        while (n_done == 0 && guard < 5000) begin
            guard++;
            if (rs == 1) begin start = 1; dimension = dim + 777; rs = 2; end
            else if (rs == 2) begin start = 0; dimension = dim; rs = 0; end
            x_data_in_valid = idx < nbeats && $urandom_range(99) < pct;
            x_data_in = idx < nbeats ? bq[idx] : {16{$urandom}};
            @(negedge clk);
            acc = x_data_in_valid && x_data_in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == restart_at) rs = 1;
                if (idx == abort_at) break;
            end
        end
        x_data_in_valid = 0; start = 0; dimension = dim;
        if (abort_at > 0) return;
        check("load_timeout", 64'(guard >= 5000), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rd_start_count", 64'(n_rd_start), 64'(dim != 0));
        if (dim != 0 && rd_addr_q.size() > 0) begin
            check("rd_addr", rd_addr_q[0], addr);
            check("rd_length", 64'(rd_len_q[0]), 64'(nbeats * 64));
            check("rd_addr_hold", x_data_rd_addr, addr);
        end
        check("wr_count", 64'(wr_row_q.size()), 64'(nbeats / GROUP));
        for (int j = 0; j < wr_row_q.size() && j < nbeats / GROUP; j++) begin
            check("wr_row", 64'(wr_row_q[j]), 64'(j / EN));
            check("wr_en", 64'(wr_en_q[j]), 64'(1 << (j % EN)));
            check("wr_data", wr_fp_q[j],
                  fold({bq[4*j+3], bq[4*j+2], bq[4*j+1], bq[4*j]}));
        end
        check("done_count", 64'(n_done), 64'd1);
        check("done_with_last_wr", 64'(done_with_wr), 64'(dim != 0));
        if (dim == 0) check("done_latency", 64'(done_cyc - s + 1), 64'd2);
        check("beat_count", 64'(state_counters[27:0]), 64'(nbeats));
        check("state_idle", 64'(state_counters[31:28]), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(x_data_in_ready), 64'd0);
        check("rst_rd_start", 64'(x_data_rd_start), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_wr_en", 64'(x_mem_wr_en), 64'd0);
        check("rst_counters", 64'(state_counters), 64'd0);
        rst = 0;
        @(posedge clk); #1;

        run_load(512, 64'h1000, 100, 0, 0);
        run_load(1000, 64'h2_0000_0040, 50, 0, 0);
        run_load(0, 64'h3000, 100, 0, 0);
        run_load(512, 64'h4000, 70, 13, 0);

        run_load(512, 64'h5000, 100, 0, 10);
        rst = 1;
        x_data_in_valid = 1;
        @(posedge clk); #1;
        check("abort_ready", 64'(x_data_in_ready), 64'd0);
        check("abort_wr_en", 64'(x_mem_wr_en), 64'd0);
        check("abort_rd_len", 64'(x_data_rd_length), 64'd0);
        check("abort_rd_addr", x_data_rd_addr, 64'd0);
        check("abort_counters", 64'(state_counters), 64'd0);
        check("abort_wr_data", fold(x_mem_wr_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        x_data_in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_wr_count", 64'(wr_row_q.size()), 64'd2);
        run_load(512, 64'h6000, 100, 0, 0);

        clear_mon();
        x_data_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(x_data_in_ready), 64'd0);
        end
        x_data_in_valid = 0;
        @(posedge clk); #1;
        check("idle_beats", 64'(state_counters[27:0]), 64'd32);
        check("idle_no_wr", 64'(wr_row_q.size()), 64'd0);

        for (int t = 0; t < 4; t++)
            run_load(int'($urandom_range(2500, 1)), {$urandom, $urandom} & ~64'h3f,
                     int'($urandom_range(100, 30)), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
